// File: rtl/uart_rx_packer.sv
// uart_rx_packer: 8N1 UART receiver that packs consecutive characters into one wide
// word and holds it in a valid/ready output register. Characters with a bad stop bit
// raise a one-cycle frame_err and are dropped. A complete word that arrives while the
// output register is still full is dropped and sets the sticky overrun flag.
module uart_rx_packer #(
   parameter int CLOCKS_PER_PULSE = 200_000_000 / 9600,
   parameter int BITS_PER_WORD    = 8,
   parameter int W_OUT            = 576
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx,
   input  logic             m_ready,
   output logic             m_valid,
   output logic [W_OUT-1:0] m_data,
   output logic             frame_err,
   output logic             overrun
);

   // Characters per packed word, and counter widths (each at least one bit).
   localparam int N     = W_OUT / BITS_PER_WORD;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int CNT_W = $clog2(CLOCKS_PER_PULSE);
   localparam int BIT_W = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_PULSE - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_WORD - 1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   // Receiver states.
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   // Two-flop synchroniser for the asynchronous serial line.
   logic rx_meta_q, rx_meta_d;
   logic rx_s_q,    rx_s_d;

   // Bit-level receiver.
   logic [1:0]               state_q,   state_d;
   logic [CNT_W-1:0]         cnt_q,     cnt_d;
   logic [BIT_W-1:0]         bit_idx_q, bit_idx_d;
   logic [BITS_PER_WORD-1:0] shift_q,   shift_d;
   logic [BITS_PER_WORD:0]   shift_cat;
   // armed_q: a high line sample has been seen since the last character ended, so a
   // low level in IDLE is a genuine start edge rather than a continuing break.
   logic                     armed_q,   armed_d;
   logic                     byte_ok;
   logic                     frame_bad;

   // Word packer and output register.
   logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
   logic [W_OUT-1:0] acc_q,      acc_d;
   logic [N-1:0]     slot_wr;
   logic             word_done;
   logic             drain;
   logic             load_word;
   logic             m_valid_q,   m_valid_d;
   logic [W_OUT-1:0] m_data_q,    m_data_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q,   overrun_d;

   // Synchroniser next-state: shift rx through two stages.
   always_comb begin
      rx_meta_d = rx;
      rx_s_d    = rx_meta_q;
   end

   // Receiver FSM: start-bit qualification at mid-bit, then one sample per bit period.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      armed_d   = armed_q;
      byte_ok   = 1'b0;
      frame_bad = 1'b0;
      shift_cat = {rx_s_q, shift_q};

      case (state_q)
         S_IDLE: begin
            if (!rx_s_q && armed_q) begin
               state_d = S_START;
               cnt_d   = '0;
            end else if (rx_s_q) begin
               armed_d = 1'b1;
            end
         end

         S_START: begin
            if (cnt_q == CNT_MID) begin
               cnt_d = '0;
               if (!rx_s_q) begin
                  state_d   = S_DATA;
                  bit_idx_d = '0;
               end else begin
                  // Line was back high by mid-bit: treat as a glitch, silently.
                  state_d = S_IDLE;
                  armed_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         S_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               // LSB arrives first, so new bits enter at the top and shift down.
               shift_d = shift_cat[BITS_PER_WORD:1];
               if (bit_idx_q == BIT_LAST) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + BIT_ONE;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         S_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               // Return to IDLE immediately so a start bit right after the stop
               // bit is caught. A low stop bit leaves us disarmed until the line
               // has been seen high again, so a break yields one error only.
               state_d = S_IDLE;
               armed_d = rx_s_q;
               if (rx_s_q) begin
                  byte_ok = 1'b1;
               end else begin
                  frame_bad = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Per-slot accumulator write: the accepted character lands in slot byte_idx_q.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_slot
         assign slot_wr[gi] = byte_ok && (byte_idx_q == IDX_W'(gi));
         assign acc_d[gi*BITS_PER_WORD +: BITS_PER_WORD] =
            slot_wr[gi] ? shift_q : acc_q[gi*BITS_PER_WORD +: BITS_PER_WORD];
      end
   endgenerate

   // Packer control and output register: load a finished word when the register
   // is free or emptying this cycle, otherwise drop it and flag the overrun.
   always_comb begin
      word_done = byte_ok && (byte_idx_q == IDX_LAST);
      drain     = m_valid_q && m_ready;
      load_word = word_done && (!m_valid_q || m_ready);

      byte_idx_d = byte_idx_q;
      if (byte_ok) begin
         byte_idx_d = (byte_idx_q == IDX_LAST) ? '0 : (byte_idx_q + IDX_ONE);
      end

      // acc_d already contains the final character, so it is the complete word.
      m_data_d = load_word ? acc_d : m_data_q;

      m_valid_d = m_valid_q;
      if (load_word) begin
         m_valid_d = 1'b1;
      end else if (drain) begin
         m_valid_d = 1'b0;
      end

      overrun_d   = overrun_q || (word_done && !load_word);
      frame_err_d = frame_bad;
   end

   // State registers; reset discards any partial character or partial word.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         armed_q     <= 1'b1;
         byte_idx_q  <= '0;
         acc_q       <= '0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         rx_meta_q   <= rx_meta_d;
         rx_s_q      <= rx_s_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         armed_q     <= armed_d;
         byte_idx_q  <= byte_idx_d;
         acc_q       <= acc_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign m_valid   = m_valid_q;
   assign m_data    = m_data_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_packer.sv
// tb_uart_rx_packer: directed stimulus for uart_rx_packer with 16 clocks per bit and
// 32-bit words; expected words are written out by hand from the bytes sent.
module tb_uart_rx_packer;

   localparam int CPP = 16;
   localparam int W   = 32;

   logic         clk     = 1'b0;
   logic         rst     = 1'b1;
   logic         rx      = 1'b1;
   logic         m_ready = 1'b0;
   logic         m_valid;
   logic [W-1:0] m_data;
   logic         frame_err;
   logic         overrun;

   int           n_checks  = 0;
   int           n_errors  = 0;
   int           fe_cnt    = 0;
   logic [W-1:0] got_q[$];
   logic         toggle_en = 1'b0;
   logic         stall_prev = 1'b0;
   logic [W-1:0] data_prev  = '0;

   uart_rx_packer #(
      .CLOCKS_PER_PULSE(CPP),
      .BITS_PER_WORD   (8),
      .W_OUT           (W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx),
      .m_ready  (m_ready),
      .m_valid  (m_valid),
      .m_data   (m_data),
      .frame_err(frame_err),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] word_at(input int k);
      return (got_q.size() > k) ? got_q[k] : {W{1'bx}};
   endfunction

   // Advance n clocks; inputs change 1 time unit after the edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (toggle_en) m_ready = ~m_ready;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      $display("send byte=0x%02h stop=%0d", b, stop);
      rx = 1'b0;
      tick(CPP);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPP);
      end
      rx = stop;
      tick(CPP);
   endtask

   task automatic send_word(input logic [W-1:0] w);
      for (int k = 0; k < W / 8; k++) begin
         send_byte(w[8*k +: 8], 1'b1);
      end
   endtask

   task automatic clear_log();
      got_q.delete();
      fe_cnt = 0;
   endtask

   // Output monitor: logs transfers, counts frame_err cycles, checks stall stability.
   always @(negedge clk) begin
      if (!rst) begin
         if (stall_prev) begin
            check_eq("stall_valid", 32'(m_valid), 32'd1);
            check_eq("stall_data", m_data, data_prev);
         end
         if (m_valid && m_ready) begin
            got_q.push_back(m_data);
            $display("xfer data=0x%08h", m_data);
         end
         if (frame_err) fe_cnt++;
      end
      stall_prev = !rst && m_valid && !m_ready;
      data_prev  = m_data;
   end

   initial begin
      // Reset values
      rst = 1'b1;
      tick(3);
      check_eq("rst_valid", 32'(m_valid), 32'd0);
      check_eq("rst_data", m_data, 32'h0);
      check_eq("rst_ferr", 32'(frame_err), 32'd0);
      check_eq("rst_ovr", 32'(overrun), 32'd0);
      rst = 1'b0;
      tick(5);

      // 1: single word, ready high
      clear_log();
      m_ready = 1'b1;
      send_word(32'h44332211);
      tick(4);
      check_eq("t1_count", 32'(got_q.size()), 32'd1);
      check_eq("t1_data", word_at(0), 32'h44332211);
      check_eq("t1_ferr", 32'(fe_cnt), 32'd0);
      check_eq("t1_ovr", 32'(overrun), 32'd0);
      check_eq("t1_valid", 32'(m_valid), 32'd0);

      // 2: stalled output, second word dropped
      clear_log();
      m_ready = 1'b0;
      send_word(32'h04030201);
      send_word(32'h08070605);
      tick(4);
      check_eq("t2_valid", 32'(m_valid), 32'd1);
      check_eq("t2_hold", m_data, 32'h04030201);
      check_eq("t2_ovr", 32'(overrun), 32'd1);
      check_eq("t2_none", 32'(got_q.size()), 32'd0);
      m_ready = 1'b1;
      tick(1);
      check_eq("t2_fall", 32'(m_valid), 32'd0);
      tick(3);
      check_eq("t2_count", 32'(got_q.size()), 32'd1);
      check_eq("t2_data", word_at(0), 32'h04030201);
      check_eq("t2_sticky", 32'(overrun), 32'd1);
      rst = 1'b1;
      tick(2);
      check_eq("t2_ovr_clr", 32'(overrun), 32'd0);
      rst = 1'b0;
      tick(3);

      // 3: framing error then a good word
      clear_log();
      send_byte(8'hA5, 1'b0);
      rx = 1'b1;
      tick(CPP);
      send_word(32'h04030201);
      tick(4);
      check_eq("t3_ferr", 32'(fe_cnt), 32'd1);
      check_eq("t3_count", 32'(got_q.size()), 32'd1);
      check_eq("t3_data", word_at(0), 32'h04030201);
      check_eq("t3_ovr", 32'(overrun), 32'd0);

      // 4: short low glitch is ignored
      clear_log();
      rx = 1'b0;
      tick(4);
      rx = 1'b1;
      tick(3 * CPP);
      check_eq("t4_none", 32'(got_q.size()), 32'd0);
      check_eq("t4_ferr", 32'(fe_cnt), 32'd0);
      check_eq("t4_valid", 32'(m_valid), 32'd0);
      send_word(32'h40302010);
      tick(4);
      check_eq("t4_count", 32'(got_q.size()), 32'd1);
      check_eq("t4_data", word_at(0), 32'h40302010);

      // 5: reset mid-word and mid-character
      clear_log();
      send_byte(8'h55, 1'b1);
      send_byte(8'h66, 1'b1);
      rx = 1'b0;
      tick(3 * CPP);
      rst = 1'b1;
      tick(2);
      rx = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(CPP);
      check_eq("t5_valid", 32'(m_valid), 32'd0);
      send_word(32'hEFBEADDE);
      tick(4);
      check_eq("t5_count", 32'(got_q.size()), 32'd1);
      check_eq("t5_data", word_at(0), 32'hEFBEADDE);
      check_eq("t5_ferr", 32'(fe_cnt), 32'd0);

      // 6: back-to-back frames, ready toggling every cycle
      clear_log();
      m_ready   = 1'b0;
      toggle_en = 1'b1;
      send_word(32'h13121110);
      send_word(32'h23222120);
      send_word(32'h33323130);
      tick(10);
      toggle_en = 1'b0;
      m_ready   = 1'b1;
      tick(4);
      check_eq("t6_count", 32'(got_q.size()), 32'd3);
      check_eq("t6_w0", word_at(0), 32'h13121110);
      check_eq("t6_w1", word_at(1), 32'h23222120);
      check_eq("t6_w2", word_at(2), 32'h33323130);
      check_eq("t6_ovr", 32'(overrun), 32'd0);
      check_eq("t6_ferr", 32'(fe_cnt), 32'd0);
      check_eq("t6_valid", 32'(m_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
